// File: rtl/iir_biquad_cascade.sv
// iir_biquad_cascade
//   Cascade of N_STAGES Direct-Form-I biquads sharing one time-multiplexed
//   multiplier. Each stage takes five MAC cycles and one write-back cycle.
//   Stage outputs are rounded and saturated. Coefficients can be written
//   while idle, and bypass can be selected per sample.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   i_valid/i_ready   input sample handshake
//   i_sample          signed input sample (FXP_SIZE)
//   i_bypass          latched at accept; output = input, history frozen
//   i_clear           flush all x/y history (honoured in IDLE only)
//   coef_we/addr/wdata  coefficient write, addr = stage*5 + {b0,b1,b2,a1,a2}
//   coef_err          one-cycle pulse for a rejected write
//   o_valid           one-cycle output strobe (DONE)
//   o_sample, o_sat   filtered sample and any-stage-saturated flag
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | ready for a sample; coefficient writes accepted
// MAC   | one tap product per cycle, taps 0..4
// WB    | round/saturate, shift history, next stage or DONE
// DONE  | o_valid strobe, return to IDLE
module iir_biquad_cascade #(
    parameter int FXP_SIZE  = 16,
    parameter int FXP_FRAC  = 12,
    parameter int COEF_SIZE = 18,
    parameter int COEF_FRAC = 14,
    parameter int N_STAGES  = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_valid,
    output logic                              i_ready,
    input  logic signed [FXP_SIZE-1:0]        i_sample,
    input  logic                              i_bypass,
    input  logic                              i_clear,
    input  logic                              coef_we,
    input  logic [$clog2(5*N_STAGES)-1:0]     coef_addr,
    input  logic signed [COEF_SIZE-1:0]       coef_wdata,
    output logic                              coef_err,
    output logic                              o_valid,
    output logic signed [FXP_SIZE-1:0]        o_sample,
    output logic                              o_sat
);
    localparam int ADDR_W = $clog2(5*N_STAGES);
    localparam int STG_W  = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int PROD_W = FXP_SIZE + COEF_SIZE;
    localparam int ACC_W  = PROD_W + 3;
    localparam int N_COEF = 5 * N_STAGES;

    localparam logic signed [COEF_SIZE-1:0] COEF_ONE = COEF_SIZE'(64'sd1 <<< COEF_FRAC);
    localparam logic signed [ACC_W-1:0]     RND      = ACC_W'(64'sd1 <<< (COEF_FRAC-1));
    localparam logic signed [ACC_W-1:0]     SAT_MAX  = ACC_W'((64'sd1 <<< (FXP_SIZE-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0]     SAT_MIN  = ~SAT_MAX;

    // Fractional bits must fit inside the sample word.
    if (FXP_FRAC >= FXP_SIZE) begin : g_bad_frac
        $error("FXP_FRAC must be smaller than FXP_SIZE");
    end

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_DONE} state_t;

    state_t state_q, state_d;
    logic [STG_W-1:0]               stage_q, stage_d;
    logic [2:0]                     tap_q, tap_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic signed [FXP_SIZE-1:0]     x_in_q, x_in_d;
    logic signed [FXP_SIZE-1:0]     sample_q, sample_d;
    logic                           bypass_q, bypass_d;
    logic                           sat_any_q, sat_any_d;
    logic signed [COEF_SIZE-1:0]    coef_q [N_COEF];
    logic signed [COEF_SIZE-1:0]    coef_d [N_COEF];
    logic signed [FXP_SIZE-1:0]     x1_q [N_STAGES], x1_d [N_STAGES];
    logic signed [FXP_SIZE-1:0]     x2_q [N_STAGES], x2_d [N_STAGES];
    logic signed [FXP_SIZE-1:0]     y1_q [N_STAGES], y1_d [N_STAGES];
    logic signed [FXP_SIZE-1:0]     y2_q [N_STAGES], y2_d [N_STAGES];
    logic signed [FXP_SIZE-1:0]     o_sample_q, o_sample_d;
    logic                           o_sat_q, o_sat_d;
    logic                           coef_err_q, coef_err_d;

    logic [ADDR_W-1:0]              coef_idx;
    logic signed [COEF_SIZE-1:0]    coef_sel;
    logic signed [FXP_SIZE-1:0]     op_sel;
    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_W-1:0]        prod_ext;
    logic signed [ACC_W-1:0]        acc_rnd;
    logic signed [ACC_W-1:0]        r_full;
    logic                           r_ovf;
    logic signed [FXP_SIZE-1:0]     r_sat;
    logic                           last_stage;
    logic                           addr_ok;

    // Shared multiplier: operand and coefficient selected by (stage, tap).
    always_comb begin
        coef_idx = ADDR_W'(stage_q * 5 + tap_q);
        coef_sel = coef_q[coef_idx];
        case (tap_q)
            3'd0:    op_sel = x_in_q;
            3'd1:    op_sel = x1_q[stage_q];
            3'd2:    op_sel = x2_q[stage_q];
            3'd3:    op_sel = y1_q[stage_q];
            default: op_sel = y2_q[stage_q];
        endcase
        prod     = PROD_W'(op_sel) * PROD_W'(coef_sel);
        prod_ext = {{3{prod[PROD_W-1]}}, prod};
        acc_rnd  = acc_q + RND;
        r_full   = acc_rnd >>> COEF_FRAC;
        r_ovf    = (r_full > SAT_MAX) || (r_full < SAT_MIN);
        if (r_ovf) begin
            r_sat = r_full[ACC_W-1] ? SAT_MIN[FXP_SIZE-1:0] : SAT_MAX[FXP_SIZE-1:0];
        end else begin
            r_sat = r_full[FXP_SIZE-1:0];
        end
        last_stage = (stage_q == STG_W'(N_STAGES-1));
        addr_ok    = (32'(coef_addr) < N_COEF);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_valid) state_d = S_MAC;
            S_MAC:   if (tap_q == 3'd4) state_d = S_WB;
            S_WB:    state_d = last_stage ? S_DONE : S_MAC;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        i_ready = (state_q == S_IDLE);
        o_valid = (state_q == S_DONE);
    end

    // Datapath next values
    always_comb begin
        stage_d    = stage_q;
        tap_d      = tap_q;
        acc_d      = acc_q;
        x_in_d     = x_in_q;
        sample_d   = sample_q;
        bypass_d   = bypass_q;
        sat_any_d  = sat_any_q;
        coef_d     = coef_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        y1_d       = y1_q;
        y2_d       = y2_q;
        o_sample_d = o_sample_q;
        o_sat_d    = o_sat_q;
        coef_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Write lands at the accept edge, so a simultaneous sample uses it.
                if (coef_we) begin
                    if (addr_ok) coef_d[coef_addr] = coef_wdata;
                    else         coef_err_d = 1'b1;
                end
                if (i_clear) begin
                    for (int s = 0; s < N_STAGES; s++) begin
                        x1_d[s] = '0;
                        x2_d[s] = '0;
                        y1_d[s] = '0;
                        y2_d[s] = '0;
                    end
                end
                if (i_valid) begin
                    sample_d  = i_sample;
                    x_in_d    = i_sample;
                    bypass_d  = i_bypass;
                    stage_d   = '0;
                    tap_d     = '0;
                    sat_any_d = 1'b0;
                end
            end
            S_MAC: begin
                coef_err_d = coef_we;
                if (tap_q == 3'd0)      acc_d = prod_ext;
                else if (tap_q >= 3'd3) acc_d = acc_q - prod_ext;
                else                    acc_d = acc_q + prod_ext;
                tap_d = tap_q + 3'd1;
            end
            S_WB: begin
                coef_err_d = coef_we;
                if (!bypass_q) begin
                    x2_d[stage_q] = x1_q[stage_q];
                    x1_d[stage_q] = x_in_q;
                    y2_d[stage_q] = y1_q[stage_q];
                    y1_d[stage_q] = r_sat;
                end
                sat_any_d = sat_any_q | r_ovf;
                x_in_d    = r_sat;
                tap_d     = '0;
                if (last_stage) begin
                    o_sample_d = bypass_q ? sample_q : r_sat;
                    o_sat_d    = bypass_q ? 1'b0 : (sat_any_q | r_ovf);
                end else begin
                    stage_d = stage_q + 1'b1;
                end
            end
            default: begin
                coef_err_d = coef_we;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q    <= '0;
            tap_q      <= '0;
            acc_q      <= '0;
            x_in_q     <= '0;
            sample_q   <= '0;
            bypass_q   <= 1'b0;
            sat_any_q  <= 1'b0;
            o_sample_q <= '0;
            o_sat_q    <= 1'b0;
            coef_err_q <= 1'b0;
            for (int i = 0; i < N_COEF; i++) begin
                coef_q[i] <= ((i % 5) == 0) ? COEF_ONE : '0;
            end
            for (int s = 0; s < N_STAGES; s++) begin
                x1_q[s] <= '0;
                x2_q[s] <= '0;
                y1_q[s] <= '0;
                y2_q[s] <= '0;
            end
        end else begin
            stage_q    <= stage_d;
            tap_q      <= tap_d;
            acc_q      <= acc_d;
            x_in_q     <= x_in_d;
            sample_q   <= sample_d;
            bypass_q   <= bypass_d;
            sat_any_q  <= sat_any_d;
            o_sample_q <= o_sample_d;
            o_sat_q    <= o_sat_d;
            coef_err_q <= coef_err_d;
            coef_q     <= coef_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            y1_q       <= y1_d;
            y2_q       <= y2_d;
        end
    end

    assign o_sample = o_sample_q;
    assign o_sat    = o_sat_q;
    assign coef_err = coef_err_q;

endmodule

// File: doc/iir_biquad_cascade.md
Name: iir_biquad_cascade

Overview:
- Parametrised successor to the fixed 4th-order preprocessing IIR.
- Implements N_STAGES cascaded Direct-Form-I biquad sections.
- Coefficients are runtime-loadable. One time-multiplexed multiplier is shared by all taps.
- Stage outputs are rounded and saturated. The block has a valid/ready input handshake and a per-sample bypass mode.
- Sits in the effects chain wherever a filter with configurable order and response is needed (pre-emphasis, tone stack, cab sim).

Parameters:
- FXP_SIZE, 16, sample width (signed fixed point).
- FXP_FRAC, 12, sample fractional bits. Informational only; samples pass through the arithmetic unchanged in format.
- COEF_SIZE, 18, coefficient width (signed).
- COEF_FRAC, 14, coefficient fractional bits (1.0 = 1<<COEF_FRAC).
- N_STAGES, 2, number of biquad sections (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- i_valid  in  1  input sample valid.
- i_ready  out  1  block can accept a sample.
- i_sample  in  FXP_SIZE  input sample, signed.
- i_bypass  in  1  sampled at accept; when 1 the output equals the input.
- i_clear  in  1  synchronous flush of all history registers.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(5*N_STAGES)  coefficient address = stage*5+k.
  - k: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
- coef_wdata  in  COEF_SIZE  coefficient value, signed.
- coef_err  out  1  one-cycle pulse when a write is rejected.
- o_valid  out  1  one-cycle output strobe.
- o_sample  out  FXP_SIZE  filtered sample, signed.
- o_sat  out  1  qualified by o_valid; 1 if any stage saturated for this sample.

Behaviour:
- Reset (rst=0, asynchronous), all of the following take effect immediately:
  - FSM goes to IDLE.
  - All x/y history registers are cleared to 0.
  - Coefficients for every stage are set to pass-through: b0=1<<COEF_FRAC, all others 0.
  - o_valid=0, o_sample=0, o_sat=0, coef_err=0, i_ready=1.
  - Reset mid-computation discards the in-flight sample; no o_valid is produced for it.
- FSM states: IDLE, MAC, WB, DONE.
  - IDLE: i_ready=1.
    - On i_valid: latch i_sample and i_bypass, set stage=0, tap=0, then go to MAC.
    - If bypass is latched, MAC and WB are still sequenced but history is not updated.
  - MAC: one product per cycle for tap 0..4, accumulated into acc.
    - acc = b0*x0 + b1*x1 + b2*x2 - a1*y1 - a2*y2.
    - x0 is the stage input. Stage s>0 takes its input from the stage s-1 result.
    - After tap 4, go to WB.
  - WB:
    - r = (acc + (1<<(COEF_FRAC-1))) >>> COEF_FRAC.
    - Saturate r to [-2^(FXP_SIZE-1), 2^(FXP_SIZE-1)-1] and record a sat flag.
    - Shift history: x2<=x1, x1<=x0, y2<=y1, y1<=sat(r). Skipped when bypass is latched.
    - If stage==N_STAGES-1, go to DONE; else stage++, tap=0, go to MAC.
  - DONE: o_valid=1 for exactly this cycle. o_sample and o_sat are valid. Return to IDLE.
- Output hold: o_sample holds its value until the next DONE.
- Output values:
  - Normal: o_sample = last stage result; o_sat = OR of all stage sat flags.
  - Bypass: o_sample = latched input; o_sat = 0.
- Timing:
  - The accept edge ends cycle 0.
  - Stage s occupies MAC cycles 6s+1 .. 6s+5 and WB cycle 6s+6.
  - DONE is cycle 6*N_STAGES+1. Default N_STAGES=2 gives o_valid at cycle 13.
  - Throughput: one sample per 6*N_STAGES+2 cycles. i_ready is low outside IDLE.
- Arithmetic widths:
  - Products are FXP_SIZE+COEF_SIZE bits.
  - acc is FXP_SIZE+COEF_SIZE+3 bits, so it cannot overflow before rounding.
  - All arithmetic is signed; the shift is arithmetic.
- Coefficient writes:
  - Accepted only in IDLE; they take effect for the next accepted sample.
  - A write while not in IDLE, or with coef_addr ≥ 5*N_STAGES, is dropped and coef_err pulses the next cycle.
  - If coef_we and i_valid are both asserted in IDLE, the write is applied first and the accepted sample uses the new coefficient.
- i_clear:
  - In IDLE, zeroes the history; if i_valid is also asserted, the sample is accepted and computed with the cleared history.
  - Outside IDLE, i_clear is ignored.

Test Plan:
- Reset defaults, N_STAGES=2: accept i_sample=0x0800 → o_valid exactly 13 cycles after the accept edge with o_sample=0x0800, o_sat=0. i_ready low for cycles 1..13.
- Gain: write addr 0 = 0x02000 (stage0 b0=0.5), accept 0x1000 → o_sample=0x0800. Then accept 0xF000 → o_sample=0xF800.
- Recursion: stage0 b0=0x04000, a1=0x3E000 (-0.5). Impulse 0x1000 followed by zeros → outputs 0x1000, 0x0800, 0x0400, 0x0200, 0x0100.
- Saturation: stage0 b0=0x08000 (2.0).
  - Input 0x7000 → o_sample=0x7FFF, o_sat=1.
  - Input 0x9000 → o_sample=0x8000, o_sat=1.
  - Input 0x1000 → 0x2000, o_sat=0.
- Handshake/config faults:
  - coef_we while in MAC → coef_err pulse; the coefficient is unchanged on the next sample.
  - coef_addr=10 with N_STAGES=2 → coef_err pulse.
  - i_bypass=1 with non-trivial coefficients → o_sample equals input, and history is unchanged on the next sample.
- Reset mid-operation: assert rst at cycle 7 of a computation → outputs clear immediately, no o_valid for that sample, coefficients return to pass-through, i_ready=1 after release.
